jtag_seg_regs: RTL and testbench

JTAG_SEG_REGS -- requirements
Module: jtag_seg_regs

---
 rtl/jtag_seg_regs.sv | 175 +++++++++++++++++
 tb/tb_jtag_seg_regs.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_seg_regs.sv
// jtag_seg_regs: JTAG user-chain register file for a 4-digit 7-segment display.
//
// The JTAG pins are oversampled in the clk domain. A 20-bit data register (DR)
// is shifted on drck rising edges and committed on update rising edges. The DR
// frame is {write flag, addr[2:0], data[15:0]}. Every committed update reloads
// DR with {1'b0, addr, read data}, so the next scan returns that data on tdo.
//
// Ports:
//   clk, rst_n          : system clock and asynchronous active-low reset
//   tdi_in              : serial data from the tap
//   reset_in            : test-logic-reset indication (asynchronous)
//   shift_in, update_in : JTAG shift and update (asynchronous)
//   sel_in, drck_in     : user-chain select and data clock (asynchronous)
//   tdo_out             : serial data back to the tap
//   disp_value_out      : four display nibbles
//   digit_en_out        : per-digit enable (forced low while blanked)
//   dp_out              : per-digit decimal point
//   wr_strobe_out       : one-clk pulse per accepted register write
module jtag_seg_regs #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tdi_in,
  input  logic        reset_in,
  input  logic        shift_in,
  input  logic        update_in,
  input  logic        sel_in,
  input  logic        drck_in,
  output logic        tdo_out,
  output logic [15:0] disp_value_out,
  output logic [3:0]  digit_en_out,
  output logic [3:0]  dp_out,
  output logic        wr_strobe_out
);

  localparam int NSYNC = 6;

  logic [NSYNC-1:0] raw_s;
  logic [NSYNC-1:0] sync_q [SYNC_STAGES];
  logic [NSYNC-1:0] sync_s;
  logic             drck_s, shift_s, upd_s, sel_s, rst_jtag_s, tdi_s;
  logic             drck_dly_q, upd_dly_q;
  logic             drck_rise_s, upd_rise_s;

  logic [19:0] dr_q, dr_d;
  logic        tdo_q, tdo_d;
  logic [15:0] disp_q, disp_d;
  logic [8:0]  ctrl_q, ctrl_d;
  logic [15:0] scan_q, scan_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [3:0]  digit_en_q, digit_en_d;
  logic [2:0]  addr_s;
  logic [15:0] rdata_s;

  assign raw_s = {tdi_in, reset_in, sel_in, update_in, shift_in, drck_in};

  // Synchronizer chains for all JTAG-side inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {NSYNC{1'b0}};
      end
    end else begin
      sync_q[0] <= raw_s;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_s     = sync_q[SYNC_STAGES-1];
  assign drck_s     = sync_s[0];
  assign shift_s    = sync_s[1];
  assign upd_s      = sync_s[2];
  assign sel_s      = sync_s[3];
  assign rst_jtag_s = sync_s[4];
  assign tdi_s      = sync_s[5];

  // Delayed copies for rising-edge detection; they keep tracking during
  // test-logic-reset so a level held across its release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drck_dly_q <= 1'b0;
      upd_dly_q  <= 1'b0;
    end else begin
      drck_dly_q <= drck_s;
      upd_dly_q  <= upd_s;
    end
  end

  assign drck_rise_s = drck_s & ~drck_dly_q;
  assign upd_rise_s  = upd_s & ~upd_dly_q;
  assign addr_s      = dr_q[18:16];

  // Next-state logic: test-logic-reset beats update, update beats shift.
  always_comb begin
    dr_d        = dr_q;
    tdo_d       = tdo_q;
    disp_d      = disp_q;
    ctrl_d      = ctrl_q;
    scan_d      = scan_q;
    wr_strobe_d = 1'b0;
    rdata_s     = 16'h0000;
    if (rst_jtag_s) begin
      dr_d  = 20'h00000;
      tdo_d = 1'b0;
    end else if (upd_rise_s && sel_s) begin
      scan_d = scan_q + 16'd1;
      if (dr_q[19]) begin
        case (addr_s)
          3'd0: begin
            disp_d      = dr_q[15:0];
            wr_strobe_d = 1'b1;
          end
          3'd1: begin
            ctrl_d      = dr_q[8:0];
            wr_strobe_d = 1'b1;
          end
          default: wr_strobe_d = 1'b0;
        endcase
      end else begin
        wr_strobe_d = 1'b0;
      end
      // Read data is the value after this update's write/increment.
      case (addr_s)
        3'd0:    rdata_s = disp_d;
        3'd1:    rdata_s = {7'h00, ctrl_d};
        3'd2:    rdata_s = scan_d;
        default: rdata_s = 16'h0000;
      endcase
      dr_d = {1'b0, addr_s, rdata_s};
    end else if (drck_rise_s && sel_s && shift_s) begin
      dr_d  = {tdi_s, dr_q[19:1]};
      tdo_d = dr_q[0];
    end else begin
      dr_d  = dr_q;
      tdo_d = tdo_q;
    end
    // Computed from the next control value so the enables move with dp_out.
    if (ctrl_d[8]) begin
      digit_en_d = 4'h0;
    end else begin
      digit_en_d = ctrl_d[3:0];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dr_q        <= 20'h00000;
      tdo_q       <= 1'b0;
      disp_q      <= 16'h0000;
      ctrl_q      <= 9'h000;
      scan_q      <= 16'h0000;
      wr_strobe_q <= 1'b0;
      digit_en_q  <= 4'h0;
    end else begin
      dr_q        <= dr_d;
      tdo_q       <= tdo_d;
      disp_q      <= disp_d;
      ctrl_q      <= ctrl_d;
      scan_q      <= scan_d;
      wr_strobe_q <= wr_strobe_d;
      digit_en_q  <= digit_en_d;
    end
  end

  assign tdo_out        = tdo_q;
  assign disp_value_out = disp_q;
  assign digit_en_out   = digit_en_q;
  assign dp_out         = ctrl_q[7:4];
  assign wr_strobe_out  = wr_strobe_q;

endmodule

// File: tb/tb_jtag_seg_regs.sv
// Self-checking bench for jtag_seg_regs: directed scans plus random register
// transactions compared against a register-level model of the chain.
module tb_jtag_seg_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tdi_in = 1'b0, reset_in = 1'b0, shift_in = 1'b0;
  logic        update_in = 1'b0, sel_in = 1'b0, drck_in = 1'b0;
  logic        tdo_out;
  logic [15:0] disp_value_out;
  logic [3:0]  digit_en_out, dp_out;
  logic        wr_strobe_out;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;

  // Model: architectural registers plus the word the next scan must return.
  logic [15:0] m_disp, m_ctrl, m_scan;
  logic [19:0] m_dr;

  jtag_seg_regs #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .tdi_in(tdi_in), .reset_in(reset_in),
    .shift_in(shift_in), .update_in(update_in), .sel_in(sel_in), .drck_in(drck_in),
    .tdo_out(tdo_out), .disp_value_out(disp_value_out), .digit_en_out(digit_en_out),
    .dp_out(dp_out), .wr_strobe_out(wr_strobe_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe_out === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  initial begin
    repeat (400000) @(posedge clk);
    $display("FAIL watchdog: observed no finish, expected finish before 400000 cycles");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [19:0] frm(input logic w, input logic [2:0] a, input logic [15:0] d);
    return {w, a, d};
  endfunction

  task automatic model_reset();
    m_disp = 16'h0000; m_ctrl = 16'h0000; m_scan = 16'h0000; m_dr = 20'h00000;
  endtask

  task automatic model_update(output logic wrote);
    logic [2:0]  a;
    logic [15:0] rd;
    a = m_dr[18:16];
    wrote = 1'b0;
    m_scan = m_scan + 16'd1;
    if (m_dr[19] && a == 3'd0) begin m_disp = m_dr[15:0]; wrote = 1'b1; end
    if (m_dr[19] && a == 3'd1) begin m_ctrl = m_dr[15:0] & 16'h01FF; wrote = 1'b1; end
    if (a == 3'd0)      rd = m_disp;
    else if (a == 3'd1) rd = m_ctrl;
    else if (a == 3'd2) rd = m_scan;
    else                rd = 16'h0000;
    m_dr = {1'b0, a, rd};
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_disp"}, disp_value_out, m_disp);
    check({tag, "_dp"}, dp_out, m_ctrl[7:4]);
    check({tag, "_digit_en"}, digit_en_out, m_ctrl[8] ? 4'h0 : m_ctrl[3:0]);
  endtask

  task automatic shift_bit(input logic b, input logic sel, output logic t);
    tdi_in = b; sel_in = sel; shift_in = 1'b1; drck_in = 1'b0;
    wait_clks(6);
    drck_in = 1'b1;
    wait_clks(6);
    t = tdo_out;
    drck_in = 1'b0;
  endtask

  // Shifts a whole frame (LSB first); the bits seen on tdo are the prior DR.
  task automatic shift_frame(input logic [19:0] frame, input logic sel, input string tag);
    logic [19:0] got;
    logic        t0;
    t0 = tdo_out;
    for (int i = 0; i < 20; i++) shift_bit(frame[i], sel, got[i]);
    if (sel) begin
      check({tag, "_readback"}, got, m_dr);
      m_dr = frame;
    end else begin
      check({tag, "_tdo_hold"}, got, {20{t0}});
    end
  endtask

  task automatic do_update(input logic sel, input string tag);
    int   s0;
    logic w;
    s0 = strobe_cnt;
    shift_in = 1'b0; sel_in = sel; update_in = 1'b1;
    wait_clks(6);
    update_in = 1'b0;
    wait_clks(6);
    if (sel) model_update(w);
    else     w = 1'b0;
    check({tag, "_strobes"}, strobe_cnt - s0, {31'd0, w});
    check_outputs(tag);
  endtask

  initial begin
    logic        t, w, sel;
    logic [19:0] f;
    int          s0;

    // Power-on reset.
    model_reset();
    wait_clks(3);
    check("rst_tdo", tdo_out, 1'b0);
    check("rst_strobe", wr_strobe_out, 1'b0);
    check_outputs("rst");
    rst_n = 1'b1;
    wait_clks(4);
    check_outputs("post_rst");

    // Write 0x1234 to display, then read scan_count.
    shift_frame(frm(1'b1, 3'd0, 16'h1234), 1'b1, "w0_1234");
    do_update(1'b1, "w0_1234");
    check("disp_1234", disp_value_out, 16'h1234);
    shift_frame(frm(1'b0, 3'd2, 16'h0000), 1'b1, "rd_scan");
    do_update(1'b1, "rd_scan");

    // Control: enables visible, then blanked.
    shift_frame(frm(1'b1, 3'd1, 16'h00AF), 1'b1, "ctrl_af");
    do_update(1'b1, "ctrl_af");
    check("ctrl_dp_a", dp_out, 4'hA);
    check("ctrl_en_f", digit_en_out, 4'hF);
    shift_frame(frm(1'b1, 3'd1, 16'h01AF), 1'b1, "ctrl_blank");
    do_update(1'b1, "ctrl_blank");
    check("blank_en_0", digit_en_out, 4'h0);

    // BEEF readback on tdo (checked as 20'h0BEEF by the next scan).
    shift_frame(frm(1'b1, 3'd0, 16'hBEEF), 1'b1, "w0_beef");
    do_update(1'b1, "w0_beef");
    check("beef_frame", m_dr, 20'h0BEEF);
    shift_frame(frm(1'b1, 3'd2, 16'h5555), 1'b1, "rd_beef");
    // Write to read-only scan_count: no strobe, count readback.
    do_update(1'b1, "w2_5555");

    // sel=0: shifts and updates ignored.
    shift_frame(frm(1'b1, 3'd0, 16'h7777), 1'b0, "sel0");
    do_update(1'b0, "sel0");
    shift_frame(frm(1'b1, 3'd0, 16'hA5A5), 1'b1, "after_sel0");

    // Simultaneous drck and update edges: update wins, no shift.
    t = tdo_out;
    s0 = strobe_cnt;
    tdi_in = 1'b1; shift_in = 1'b1; sel_in = 1'b1;
    wait_clks(6);
    drck_in = 1'b1; update_in = 1'b1;
    wait_clks(6);
    drck_in = 1'b0; update_in = 1'b0;
    wait_clks(6);
    model_update(w);
    check("prec_strobes", strobe_cnt - s0, {31'd0, w});
    check("prec_tdo_hold", tdo_out, t);
    check_outputs("prec");

    // Test-logic-reset clears DR/tdo; edges during it are discarded.
    shift_frame(frm(1'b1, 3'd2, 16'h0000), 1'b1, "pre_tlr");
    reset_in = 1'b1;
    wait_clks(6);
    for (int i = 0; i < 3; i++) begin
      drck_in = 1'b1; update_in = 1'b1; wait_clks(4);
      drck_in = 1'b0; update_in = 1'b0; wait_clks(4);
    end
    reset_in = 1'b0;
    wait_clks(6);
    m_dr = 20'h00000;
    check("tlr_tdo", tdo_out, 1'b0);
    check_outputs("tlr");
    shift_frame(frm(1'b0, 3'd2, 16'h0000), 1'b1, "post_tlr");
    do_update(1'b1, "post_tlr");

    // Async reset mid-scan: aborts with no write.
    for (int i = 0; i < 10; i++) shift_bit(i[0], 1'b1, t);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_tdo", tdo_out, 1'b0);
    check("mid_rst_strobe", wr_strobe_out, 1'b0);
    check_outputs("mid_rst");
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(4);
    shift_frame(frm(1'b1, 3'd0, 16'hC0DE), 1'b1, "after_rst");
    do_update(1'b1, "after_rst");

    // Random transactions.
    for (int n = 0; n < 30; n++) begin
      f = frm(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
      sel = ($urandom_range(0, 5) != 0);
      shift_frame(f, sel, "rnd");
      do_update(sel, "rnd");
    end

    // scan_count wrap.
    rst_n = 1'b0;
    wait_clks(2);
    model_reset();
    rst_n = 1'b1;
    wait_clks(4);
    shift_frame(frm(1'b0, 3'd2, 16'h0000), 1'b1, "wrap_sel");
    do_update(1'b1, "wrap_first");
    s0 = strobe_cnt;
    shift_in = 1'b0; sel_in = 1'b1;
    while (m_scan != 16'hFFFF) begin
      update_in = 1'b1;
      @(negedge clk);
      update_in = 1'b0;
      @(negedge clk);
      model_update(w);
    end
    wait_clks(6);
    check("wrap_no_strobe", strobe_cnt - s0, 32'd0);
    shift_frame(frm(1'b0, 3'd2, 16'h0000), 1'b1, "wrap_ffff");
    check("wrap_model_ffff", m_scan, 16'hFFFF);
    do_update(1'b1, "wrap_zero");
    shift_frame(frm(1'b0, 3'd0, 16'h0000), 1'b1, "wrap_read0");
    check("wrap_model_0", m_scan, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
